gshare_fetch: RTL

Instruction fetch stage with an on-chip instruction memory, a parametrised gshare branch predictor and an optional return-address stack (RAS). It sits at the front of the pipeline. It loads the program from the host in load mode, then fetches one instruction per cycle. Fetch is redirected on jumps, predicted-taken branches, returns and pipeline flushes. The PHT is cleared by a hardware sweep after reset, and 2-bit counters are updated at branch commit.

---
 rtl/gshare_fetch.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gshare_fetch.sv
// rtl/gshare_fetch.sv - instruction fetch stage with gshare predictor and optional RAS
//
// Purpose:
//   Front-end fetch stage. In load mode the host writes the program into the
//   on-chip instruction memory. Otherwise one instruction is fetched per cycle.
//   Fetch is redirected by flush, jumps/calls, predicted-taken branches and
//   returns. A gshare PHT of 2-bit counters supplies predictions. The PHT is
//   cleared to weakly-not-taken (2'b01) by a hardware sweep after reset.
//   Counters and global history are updated at branch commit.
//
// Configuration macro:
//   RAS_EN  defined   : circular return-address stack is built and returns use
//                       its top; return_addr is ignored.
//           undefined : no RAS; returns use return_addr and calls act as jumps.
//
// Parameters:
//   INST_WIDTH     instruction width
//   ADDR_WIDTH     instruction address width (memory depth 2^ADDR_WIDTH)
//   PATTERN_WIDTH  PHT index width (PHT depth 2^PATTERN_WIDTH), <= ADDR_WIDTH
//   GH_WIDTH       global history length, 2..PATTERN_WIDTH
//   RAS_DEPTH      RAS entries, power of two >= 2
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   ready             low while the PHT clear sweep runs
//   load_mode         host program-load mode (fetch suppressed)
//   load_we, inst_in  write inst_in to mem[pc] and advance pc
//   stall             hold all fetch outputs and pc
//   flush, flush_addr redirect fetch to flush_addr (overrides stall)
//   dec_is_j/b/call/ret, dec_target
//                     same-cycle predecode of inst_out
//   return_addr       return target when there is no RAS
//   pc                next sequential fetch address
//   inst_pc, inst_out address and data of the fetched instruction
//   inst_valid        inst_out is a real fetch
//   pred_taken        prediction for inst_out
//   pattern_out       PHT index used for inst_out
//   pred_ctr_out      PHT counter read for inst_out
//   commit_b, commit_pattern, commit_ctr, commit_taken
//                     branch commit: counter update and history shift

module gshare_fetch #(
  parameter int INST_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 14,
  parameter int PATTERN_WIDTH = 10,
  parameter int GH_WIDTH      = 6,
  parameter int RAS_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     load_mode,
  input  logic                     load_we,
  input  logic [INST_WIDTH-1:0]    inst_in,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_WIDTH-1:0]    flush_addr,
  input  logic                     dec_is_j,
  input  logic                     dec_is_b,
  input  logic                     dec_is_call,
  input  logic                     dec_is_ret,
  input  logic [ADDR_WIDTH-1:0]    dec_target,
  input  logic [ADDR_WIDTH-1:0]    return_addr,
  output logic [ADDR_WIDTH-1:0]    pc,
  output logic [ADDR_WIDTH-1:0]    inst_pc,
  output logic [INST_WIDTH-1:0]    inst_out,
  output logic                     inst_valid,
  output logic                     pred_taken,
  output logic [PATTERN_WIDTH-1:0] pattern_out,
  output logic [1:0]               pred_ctr_out,
  input  logic                     commit_b,
  input  logic [PATTERN_WIDTH-1:0] commit_pattern,
  input  logic [1:0]               commit_ctr,
  input  logic                     commit_taken
);

  localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int PHT_DEPTH = 1 << PATTERN_WIDTH;

  // Elaboration-time parameter sanity checks.
  if (GH_WIDTH < 2 || GH_WIDTH > PATTERN_WIDTH) begin : g_bad_gh
    $error("gshare_fetch: GH_WIDTH must be in 2..PATTERN_WIDTH");
  end
  if (PATTERN_WIDTH > ADDR_WIDTH) begin : g_bad_pattern
    $error("gshare_fetch: PATTERN_WIDTH must not exceed ADDR_WIDTH");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
    $error("gshare_fetch: RAS_DEPTH must be a power of two >= 2");
  end

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state;
  logic [PATTERN_WIDTH-1:0] clr_idx;
  logic [GH_WIDTH-1:0]      gh;

  logic [INST_WIDTH-1:0]    mem [MEM_DEPTH];
  logic [1:0]               pht [PHT_DEPTH];

  logic [ADDR_WIDTH-1:0]    fa;
  logic [ADDR_WIDTH-1:0]    ret_target;
  logic [PATTERN_WIDTH-1:0] gh_ext;
  logic [PATTERN_WIDTH-1:0] fetch_pattern;
  logic [1:0]               ctr_next;
  logic                     jump_like;
  logic                     fetch_en;
  logic                     accept;

  // A call always redirects to its decoded target; with a RAS it also pushes.
  assign jump_like = dec_is_j | dec_is_call;

  // Fetch happens in RUN outside load mode unless stalled; flush beats stall.
  assign fetch_en = (state == RUN) && !load_mode && (!stall || flush);

  // Accepted fetch: the instruction currently in inst_out really advances.
  assign accept = (state == RUN) && !load_mode && !stall && !flush && inst_valid;

  // History occupies the top GH_WIDTH bits of the PHT index.
  assign gh_ext        = PATTERN_WIDTH'(gh) << (PATTERN_WIDTH - GH_WIDTH);
  assign fetch_pattern = fa[PATTERN_WIDTH-1:0] ^ gh_ext;

  always_comb begin
    fa = pc;
    if (flush) begin
      fa = flush_addr;
    end else if (inst_valid && jump_like) begin
      fa = dec_target;
    end else if (inst_valid && dec_is_b && pred_taken) begin
      fa = dec_target;
    end else if (inst_valid && dec_is_ret) begin
      fa = ret_target;
    end
  end

  // Saturating 2-bit counter update for the committing branch.
  always_comb begin
    ctr_next = commit_ctr;
    if (commit_taken) begin
      if (commit_ctr != 2'b11) ctr_next = commit_ctr + 2'd1;
    end else begin
      if (commit_ctr != 2'b00) ctr_next = commit_ctr - 2'd1;
    end
  end

`ifdef RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

  logic [ADDR_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]      ras_ptr;
  logic [PTR_W:0]        ras_cnt;
  logic [PTR_W-1:0]      top_idx;
  logic                  unused_return_addr;

  assign unused_return_addr = ^return_addr;

  // ras_ptr points at the next free slot; the top is the slot below it.
  assign top_idx    = ras_ptr - PTR_W'(1);
  assign ret_target = ras[top_idx];

  // Pointer and count. Underflow wraps the pointer (stale entry) but pins
  // the count at zero; overflow simply overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (accept && dec_is_call) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_MAX) ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
    end else if (accept && dec_is_ret) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      if (ras_cnt != '0) ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept && dec_is_call) begin
      ras[ras_ptr] <= inst_pc + ADDR_WIDTH'(1);
    end
  end
`else
  assign ret_target = return_addr;
`endif

  // Program memory: written only by the host in load mode.
  always_ff @(posedge clk) begin
    if (!reset && (state == RUN) && load_mode && load_we) begin
      mem[pc] <= inst_in;
    end
  end

  // PHT write port: clear sweep has the port in CLEAR, commit in RUN.
  // A fetch reading the same entry this cycle sees the old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        pht[clr_idx] <= 2'b01;
      end else if (commit_b) begin
        pht[commit_pattern] <= ctr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      ready        <= 1'b0;
      gh           <= '0;
      pc           <= '0;
      inst_pc      <= '0;
      inst_out     <= '0;
      inst_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pattern_out  <= '0;
      pred_ctr_out <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + PATTERN_WIDTH'(1);
          if (clr_idx == '1) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (commit_b) begin
            gh <= GH_WIDTH'({gh, commit_taken});
          end
          if (load_mode) begin
            inst_valid <= 1'b0;
            if (load_we) pc <= pc + ADDR_WIDTH'(1);
          end else if (fetch_en) begin
            pc           <= fa + ADDR_WIDTH'(1);
            inst_pc      <= fa;
            inst_out     <= mem[fa];
            inst_valid   <= 1'b1;
            pattern_out  <= fetch_pattern;
            pred_ctr_out <= pht[fetch_pattern];
            pred_taken   <= pht[fetch_pattern][1];
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
